// File: rtl/iir_zero_mac.sv
// Multi-channel feed-forward (zero) section: y[n] = sum_k coe[k]*x[ch][n-k],
// evaluated one tap per cycle through a single shared multiplier.
//
// state  | meaning
// IDLE   | waiting for a sample; coefficient writes allowed
// MAC    | one tap per cycle, k = 0..TAPS-1
// DONE   | Xout/out_ch valid, out_valid high for this cycle
module iir_zero_mac #(
  parameter int DW    = 24,
  parameter int CW    = 17,
  parameter int TAPS  = 3,
  parameter int NCH   = 2,
  parameter int GUARD = 2,
  parameter logic signed [CW-1:0] Z0 = 17'sd33199,
  parameter logic signed [CW-1:0] Z1 = -17'sd63005,
  parameter logic signed [CW-1:0] Z2 = 17'sd30245,
  localparam int OW  = DW + CW + GUARD,
  localparam int PW  = DW + CW,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] Xin,
  input  logic                 coe_we,
  input  logic [AW-1:0]        coe_addr,
  input  logic signed [CW-1:0] coe_wdata,
  output logic                 coe_err,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [OW-1:0] Xout
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                state, state_nx;
  logic signed [DW-1:0]  xline [NCH][TAPS];
  logic signed [CW-1:0]  coe [TAPS];
  logic [AW-1:0]         k;
  logic [CHW-1:0]        ch;
  logic signed [OW-1:0]  acc, acc_sum;
  logic signed [PW-1:0]  prod;
  logic                  ch_ok, addr_ok, last_tap, accept, coe_wr;

  function automatic logic signed [CW-1:0] coe_default(input int i);
    case (i)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      default: return '0;
    endcase
  endfunction

  assign ch_ok    = int'(in_ch) < NCH;
  assign addr_ok  = int'(coe_addr) < TAPS;
  assign last_tap = int'(k) == (TAPS - 1);

  // Full-precision product, sign-extended into the guarded accumulator.
  assign prod    = PW'(coe[k]) * PW'(xline[ch][k]);
  assign acc_sum = acc + OW'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    coe_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid && ch_ok;
        coe_wr   = coe_we && addr_ok;
        if (accept) state_nx = S_MAC;
      end
      S_MAC: begin
        if (last_tap) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < TAPS; i++)
          xline[c][i] <= '0;
      for (int i = 0; i < TAPS; i++)
        coe[i] <= coe_default(i);
      k       <= '0;
      ch      <= '0;
      acc     <= '0;
      Xout    <= '0;
      out_ch  <= '0;
      coe_err <= 1'b0;
    end else begin
      coe_err <= coe_we && !coe_wr;
      // The write lands at the accept edge, so MAC already sees the new value.
      if (coe_wr) coe[coe_addr] <= coe_wdata;
      if (accept) begin
        ch  <= in_ch;
        for (int i = TAPS - 1; i > 0; i--)
          xline[in_ch][i] <= xline[in_ch][i-1];
        xline[in_ch][0] <= Xin;
        acc <= '0;
        k   <= '0;
      end else if (state == S_MAC) begin
        acc <= acc_sum;
        k   <= k + AW'(1);
        if (last_tap) begin
          Xout   <= acc_sum;
          out_ch <= ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_zero_mac.sv
// Directed and randomized bench for iir_zero_mac against a plain-arithmetic
// convolution model of each channel's history and the coefficient bank.
module tb_iir_zero_mac;
  localparam int DW = 24, CW = 17, TAPS = 3, NCH = 3, OW = DW + CW + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [1:0]           in_ch = '0;
  logic signed [DW-1:0] Xin = '0;
  logic                 coe_we = 1'b0;
  logic [1:0]           coe_addr = '0;
  logic signed [CW-1:0] coe_wdata = '0;
  logic                 coe_err;
  logic                 out_valid;
  logic [1:0]           out_ch;
  logic signed [OW-1:0] Xout;

  iir_zero_mac #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .Xin(Xin), .coe_we(coe_we), .coe_addr(coe_addr),
    .coe_wdata(coe_wdata), .coe_err(coe_err), .out_valid(out_valid),
    .out_ch(out_ch), .Xout(Xout)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0, n_bad = 0;
  longint xh [NCH][TAPS];
  longint cm [TAPS];
  longint expq [$];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < TAPS; i++) xh[c][i] = 0;
    cm[0] = 33199; cm[1] = -63005; cm[2] = 30245;
  endtask

  task automatic model_push(input int c, input longint x, output longint y);
    for (int i = TAPS - 1; i > 0; i--) xh[c][i] = xh[c][i-1];
    xh[c][0] = x;
    y = 0;
    for (int i = 0; i < TAPS; i++) y += cm[i] * xh[c][i];
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called with cyc = cycles elapsed since the accepting edge.
  task automatic wait_out(input longint exp, input int c, input string tag, input int cyc);
    while (!out_valid && cyc < 12) begin step(); cyc++; end
    chk({tag, "_lat"}, cyc, TAPS + 1);
    chk({tag, "_xout"}, Xout, exp);
    chk({tag, "_ch"}, out_ch, c);
    step();
    chk({tag, "_ovpulse"}, out_valid, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic send(input int c, input longint x, input string tag);
    longint e;
    chk({tag, "_rdy_idle"}, in_ready, 1);
    in_valid = 1'b1; in_ch = 2'(c); Xin = DW'(x);
    model_push(c, x, e);
    step();
    in_valid = 1'b0;
    chk({tag, "_rdy_busy"}, in_ready, 0);
    wait_out(e, c, tag, 1);
  endtask

  task automatic wr_coe(input int a, input longint v, input string tag);
    bit ok;
    ok = (a < TAPS);
    coe_we = 1'b1; coe_addr = 2'(a); coe_wdata = CW'(v);
    step();
    coe_we = 1'b0;
    if (ok) cm[a] = v;
    chk({tag, "_err"}, coe_err, ok ? 0 : 1);
    step();
    chk({tag, "_err_clr"}, coe_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint e, v, x;
    int     last, nacc, c, ovs;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();
    chk("rst_ready", in_ready, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_coe_err", coe_err, 0);
    chk("rst_xout", Xout, 0);
    chk("rst_outch", out_ch, 0);

    send(0, 1, "imp0"); send(0, 0, "imp1"); send(0, 0, "imp2"); send(0, 0, "imp3");

    send(0, 1, "iso0"); send(1, 100, "iso1"); send(0, 0, "iso2");

    send(0, -8388608, "fs0"); send(0, 8388607, "fs1"); send(0, -8388608, "fs2");
    chk("fs_exact", Xout, -64'sd1060731029987);

    // Out-of-range channel: nothing accepted, nothing produced.
    in_valid = 1'b1; in_ch = 2'd3; Xin = DW'(5);
    step();
    in_valid = 1'b0;
    chk("drop_ready", in_ready, 1);
    ovs = 0;
    for (int i = 0; i < 6; i++) begin step(); ovs += int'(out_valid); end
    chk("drop_no_out", ovs, 0);

    wr_coe(1, 0, "wr1");
    wr_coe(3, 777, "wr_badaddr");
    send(2, 1, "ld0"); send(2, 0, "ld1"); send(2, 0, "ld2");

    // Write attempted during MAC is rejected and does not affect the result.
    in_valid = 1'b1; in_ch = 2'd0; Xin = DW'(7);
    model_push(0, 7, e);
    step();
    in_valid = 1'b0;
    coe_we = 1'b1; coe_addr = 2'd2; coe_wdata = CW'(999);
    step();
    coe_we = 1'b0;
    chk("busy_wr_err", coe_err, 1);
    wait_out(e, 0, "busy_wr", 2);
    chk("busy_wr_err_clr", coe_err, 0);

    // Write and accept on the same edge: new coefficient is used.
    coe_we = 1'b1; coe_addr = 2'd0; coe_wdata = CW'(1000);
    in_valid = 1'b1; in_ch = 2'd1; Xin = DW'(5);
    cm[0] = 1000;
    model_push(1, 5, e);
    step();
    coe_we = 1'b0; in_valid = 1'b0;
    chk("simul_err", coe_err, 0);
    wait_out(e, 1, "simul", 1);

    // Backpressure: in_valid held high across five samples.
    nacc = 0; last = -1;
    x = longint'($urandom_range(0, 16777215)) - 8388608;
    in_valid = 1'b1; in_ch = 2'd1; Xin = DW'(x);
    for (int cyc = 0; cyc < 60 && (nacc < 5 || expq.size() > 0); cyc++) begin
      bit took;
      took = 1'b0;
      if (in_valid && in_ready) begin
        model_push(1, x, e);
        expq.push_back(e);
        if (last >= 0) chk("bp_spacing", cyc - last, TAPS + 2);
        last = cyc; nacc++; took = 1'b1;
      end
      step();
      if (took) begin
        if (nacc == 5) in_valid = 1'b0;
        else begin
          x = longint'($urandom_range(0, 16777215)) - 8388608;
          Xin = DW'(x);
        end
      end
      if (out_valid) begin
        if (expq.size() == 0) chk("bp_extra_out", 1, 0);
        else chk("bp_xout", Xout, expq.pop_front());
      end
    end
    chk("bp_accepted", nacc, 5);
    chk("bp_drained", expq.size(), 0);
    step();

    // Reset asserted at MAC cycle 1 aborts the computation.
    in_valid = 1'b1; in_ch = 2'd0; Xin = DW'(3);
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstmac_ovalid", out_valid, 0);
    chk("rstmac_xout", Xout, 0);
    step(); step();
    rst = 1'b1;
    model_reset();
    ovs = 0;
    for (int i = 0; i < 6; i++) begin step(); ovs += int'(out_valid); end
    chk("rstmac_no_out", ovs, 0);
    send(0, 1, "post_rst");

    // Randomized mix of samples and coefficient writes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = longint'($urandom_range(0, 131071)) - 65536;
        wr_coe(int'($urandom_range(0, 3)), v, "rnd_wr");
      end else begin
        c = int'($urandom_range(0, NCH - 1));
        x = longint'($urandom_range(0, 16777215)) - 8388608;
        send(c, x, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
